mmio_uart_bridge: RTL and testbench
===================================

MMIO_UART_BRIDGE -- requirements
Module: mmio_uart_bridge

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of UART channels (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, MMIO data width.
REQ-003 SHALL have parameter TX_FIFO_DEPTH, default 4, log2 of each UART TX FIFO depth.
REQ-004 SHALL have parameter BASE_ADDR, default 16'hFF00, base of the register window on mmio_addr[15:0].
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum cycles spent waiting on a UART handshake.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port i_clk  input  1  clock.
REQ-008 SHALL have port i_rst  input  1  asynchronous active-low reset.
REQ-009 SHALL have port i_mmio_addr  input  32  request address.
REQ-010 SHALL have port i_mmio_data  input  DATA_WIDTH  write data.
REQ-011 SHALL have port i_mmio_wr_valid  input  1  write request, held until o_mmio_wr_ready.
REQ-012 SHALL have port o_mmio_wr_ready  output  1  write-accepted pulse.
REQ-013 SHALL have port i_mmio_rd_ready  input  1  read request, held until o_mmio_rd_valid.
REQ-014 SHALL have port o_mmio_rd_valid  output  1  read-data-valid pulse.
REQ-015 SHALL have port o_mmio_data  output  DATA_WIDTH  read data.
REQ-016 SHALL have ports o_uart_data (N_CH*8), o_uart_wr_valid (N_CH), i_uart_wr_ready (N_CH), i_uart_tx_free (N_CH*(TX_FIFO_DEPTH+1)), i_uart_rx_present (N_CH), i_uart_data (N_CH*8), i_uart_rd_valid (N_CH), o_uart_rd_ready (N_CH): per-channel UART TX/RX handshakes, channel c in slice c.
REQ-017 SHALL have port o_irq  output  1  registered interrupt request.
REQ-018 SHALL have port o_bad_addr  output  1  one-cycle pulse on unmapped access or timeout.

Function
REQ-019 SHALL map channel c at BASE_ADDR+4c; offsets: 0 TX (write byte / read tx_free), 1 RX data (read), 2 STATUS (read), 3 CTRL (read/write, bit0 ie_rx, bit1 ie_tx).
REQ-020 SHALL treat any address outside BASE_ADDR..BASE_ADDR+4*N_CH-1, writes to offsets 1/2, and reads of offset 0 with i_mmio_addr[31:16]!=0 as unmapped.
REQ-021 SHALL implement FSM IDLE, TX_WAIT, RX_WAIT, RESP, HOLD.
REQ-022 IDLE: write takes priority when i_mmio_wr_valid and i_mmio_rd_ready are both high; address, data and channel are latched at decode.
REQ-023 TX write: IDLE->TX_WAIT; o_uart_wr_valid[c]=1, o_uart_data slice = latched byte[7:0] until i_uart_wr_ready[c]; then RESP.
REQ-024 CTRL write and all STATUS/TX/CTRL reads: IDLE->RESP next cycle (1-cycle latency).
REQ-025 RX read with i_uart_rx_present[c]=1: IDLE->RX_WAIT; o_uart_rd_ready[c]=1 until i_uart_rd_valid[c]; byte captured; then RESP.
REQ-026 RX read with i_uart_rx_present[c]=0: RESP next cycle with data 0x100 (bit8 = empty); no UART handshake.
REQ-027 STATUS: bit0 rx_present, bit1 tx_full (tx_free==0), bit2 tx_empty (tx_free==2**TX_FIFO_DEPTH), others 0; TX read returns tx_free zero-extended.
REQ-028 RESP lasts exactly one cycle: o_mmio_wr_ready or o_mmio_rd_valid (with o_mmio_data) asserted; then HOLD.
REQ-029 HOLD returns to IDLE once both i_mmio_wr_valid and i_mmio_rd_ready are low; no request is re-decoded while held.
REQ-030 Unmapped access: RESP next cycle, read data 0, o_bad_addr pulses in the RESP cycle.
REQ-031 TX_WAIT/RX_WAIT counter; on reaching TIMEOUT cycles without UART handshake: drop UART valid/ready, go RESP, read data 0, o_bad_addr pulses.
REQ-032 o_irq registered: OR over c of (ie_rx[c] & rx_present[c]) | (ie_tx[c] & tx_empty[c]).
REQ-033 At most one o_uart_wr_valid/o_uart_rd_ready bit high at any time; o_mmio_data is 0 outside RESP.

Reset
REQ-034 On i_rst low, SHALL immediately (asynchronously) clear all outputs to 0, CTRL bits to 0, timeout counter to 0, FSM to IDLE, including mid-transaction.
REQ-035 After i_rst rises, a request still held SHALL be decoded as new on the first clock edge.

Structure
REQ-036 Shared package mmio_pkg SHALL hold register offsets, STATUS bit positions, RX-empty flag value and the FSM state enum.
REQ-037 One sub-module mmio_chan_decode SHALL convert address to {hit, channel, offset}; FSM and datapath stay in mmio_uart_bridge.

Verification
REQ-038 Write 0x41 to 0xFF04, i_uart_wr_ready[1] high after 3 cycles -> o_uart_data[15:8]=0x41, wr_valid[1] 3 cycles, o_mmio_wr_ready one pulse.
REQ-039 Read 0xFF01, rx_present[0]=1, rd_valid after 2 cycles with 0x5A -> o_mmio_data=0x5A one cycle; rx_present=0 -> 0x100, rd_ready never asserted.
REQ-040 Write 0x3 to 0xFF03, rx_present[0]=1 -> o_irq=1 next cycle; write 0 -> o_irq=0.
REQ-041 Read 0xFF10 (N_CH=2) -> data 0, o_bad_addr pulse, one rd_valid; held request -> no second response.
REQ-042 TX write, wr_ready never high -> o_bad_addr and o_mmio_wr_ready at cycle TIMEOUT+1.
REQ-043 Assert i_rst low during TX_WAIT -> o_uart_wr_valid drops without clock edge; FSM IDLE.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO-to-UART bridge: register map, STATUS/CTRL bit
// positions, the RX-empty read value and the transaction FSM states.
package mmio_pkg;

    localparam logic [1:0] OFF_TX     = 2'd0;
    localparam logic [1:0] OFF_RX     = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int STAT_RX_PRESENT = 0;
    localparam int STAT_TX_FULL    = 1;
    localparam int STAT_TX_EMPTY   = 2;

    localparam int CTRL_IE_RX = 0;
    localparam int CTRL_IE_TX = 1;

    // Bit 8 set means the RX read found no byte waiting
    localparam logic [8:0] RX_EMPTY_FLAG = 9'h100;

    typedef enum logic [2:0] {
        IDLE,
        TX_WAIT,
        RX_WAIT,
        RESP,
        HOLD
    } state_t;

    function automatic int chan_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_chan_decode.sv
// Splits the low 16 address bits into a window hit flag, a channel index and a
// register offset within that channel's 4-byte slot.
module mmio_chan_decode
    import mmio_pkg::*;
#(
    parameter int          N_CH      = 2,
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          CH_W      = chan_bits(N_CH)
) (
    input  logic [15:0]     addr,
    output logic            hit,
    output logic [CH_W-1:0] chan,
    output logic [1:0]      offset
);

    logic [16:0] rel;

    // A 17-bit difference keeps addresses below the base from wrapping into the window
    always_comb begin
        rel    = {1'b0, addr} - {1'b0, BASE_ADDR};
        hit    = (addr >= BASE_ADDR) && (rel < 17'(4 * N_CH));
        chan   = rel[CH_W+1:2];
        offset = rel[1:0];
    end

endmodule

// File: rtl/mmio_uart_bridge.sv
// Bridges a held-request MMIO bus onto N_CH UART TX/RX handshakes, with per-channel
// STATUS/CTRL registers, a handshake timeout and a registered interrupt.
module mmio_uart_bridge
    import mmio_pkg::*;
#(
    parameter int          N_CH          = 2,
    parameter int          DATA_WIDTH    = 32,
    parameter int          TX_FIFO_DEPTH = 4,
    parameter logic [15:0] BASE_ADDR     = 16'hFF00,
    parameter int          TIMEOUT       = 255
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [31:0]                       i_mmio_addr,
    input  logic [DATA_WIDTH-1:0]             i_mmio_data,
    input  logic                              i_mmio_wr_valid,
    output logic                              o_mmio_wr_ready,
    input  logic                              i_mmio_rd_ready,
    output logic                              o_mmio_rd_valid,
    output logic [DATA_WIDTH-1:0]             o_mmio_data,
    output logic [N_CH*8-1:0]                 o_uart_data,
    output logic [N_CH-1:0]                   o_uart_wr_valid,
    input  logic [N_CH-1:0]                   i_uart_wr_ready,
    input  logic [N_CH*(TX_FIFO_DEPTH+1)-1:0] i_uart_tx_free,
    input  logic [N_CH-1:0]                   i_uart_rx_present,
    input  logic [N_CH*8-1:0]                 i_uart_data,
    input  logic [N_CH-1:0]                   i_uart_rd_valid,
    output logic [N_CH-1:0]                   o_uart_rd_ready,
    output logic                              o_irq,
    output logic                              o_bad_addr
);

    localparam int                CH_W           = chan_bits(N_CH);
    localparam int                FW             = TX_FIFO_DEPTH + 1;
    localparam int                LANE_W         = N_CH * 8;
    localparam int                CNT_W          = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0]     TX_EMPTY_LEVEL = FW'(2 ** TX_FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST       = CNT_W'(TIMEOUT - 1);

    state_t                state;
    logic [CH_W-1:0]       lat_chan;
    logic [CNT_W-1:0]      wait_cnt;
    logic [N_CH-1:0]       ie_rx;
    logic [N_CH-1:0]       ie_tx;

    logic [FW-1:0]         tx_free [N_CH];
    logic [7:0]            rx_byte [N_CH];
    logic [N_CH-1:0]       tx_empty;
    logic [N_CH-1:0]       tx_full;

    logic                  hit;
    logic [CH_W-1:0]       dec_chan;
    logic [1:0]            dec_off;
    logic                  is_wr;
    logic                  mapped;
    logic [DATA_WIDTH-1:0] read_word;
    logic                  unused_wdata;

    assign unused_wdata = ^i_mmio_data[DATA_WIDTH-1:8];

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        assign tx_free[c]  = i_uart_tx_free[c*FW +: FW];
        assign rx_byte[c]  = i_uart_data[c*8 +: 8];
        assign tx_empty[c] = (tx_free[c] == TX_EMPTY_LEVEL);
        assign tx_full[c]  = (tx_free[c] == '0);
    end

    mmio_chan_decode #(
        .N_CH      (N_CH),
        .BASE_ADDR (BASE_ADDR),
        .CH_W      (CH_W)
    ) u_decode (
        .addr   (i_mmio_addr[15:0]),
        .hit    (hit),
        .chan   (dec_chan),
        .offset (dec_off)
    );

    assign is_wr = i_mmio_wr_valid;

    // Writes win over reads; RX/STATUS are read-only and TX reads need a clean upper half
    always_comb begin
        mapped = hit;
        if (is_wr && (dec_off == OFF_RX || dec_off == OFF_STATUS)) begin
            mapped = 1'b0;
        end
        if (!is_wr && dec_off == OFF_TX && i_mmio_addr[31:16] != '0) begin
            mapped = 1'b0;
        end
    end

    always_comb begin
        read_word = '0;
        case (dec_off)
            OFF_TX:     read_word = DATA_WIDTH'(tx_free[dec_chan]);
            OFF_RX:     read_word = DATA_WIDTH'(RX_EMPTY_FLAG);
            OFF_STATUS: begin
                read_word[STAT_RX_PRESENT] = i_uart_rx_present[dec_chan];
                read_word[STAT_TX_FULL]    = tx_full[dec_chan];
                read_word[STAT_TX_EMPTY]   = tx_empty[dec_chan];
            end
            default: begin
                read_word[CTRL_IE_RX] = ie_rx[dec_chan];
                read_word[CTRL_IE_TX] = ie_tx[dec_chan];
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state           <= IDLE;
            lat_chan        <= '0;
            wait_cnt        <= '0;
            ie_rx           <= '0;
            ie_tx           <= '0;
            o_mmio_wr_ready <= 1'b0;
            o_mmio_rd_valid <= 1'b0;
            o_mmio_data     <= '0;
            o_bad_addr      <= 1'b0;
            o_uart_data     <= '0;
            o_uart_wr_valid <= '0;
            o_uart_rd_ready <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_mmio_wr_valid || i_mmio_rd_ready) begin
                        lat_chan <= dec_chan;
                        wait_cnt <= '0;
                        state    <= RESP;
                        if (!mapped) begin
                            o_bad_addr      <= 1'b1;
                            o_mmio_wr_ready <= is_wr;
                            o_mmio_rd_valid <= !is_wr;
                        end else if (is_wr && dec_off == OFF_TX) begin
                            o_uart_wr_valid <= N_CH'(1) << dec_chan;
                            o_uart_data     <= LANE_W'(i_mmio_data[7:0]) << (8 * dec_chan);
                            state           <= TX_WAIT;
                        end else if (is_wr) begin
                            ie_rx[dec_chan] <= i_mmio_data[CTRL_IE_RX];
                            ie_tx[dec_chan] <= i_mmio_data[CTRL_IE_TX];
                            o_mmio_wr_ready <= 1'b1;
                        end else if (dec_off == OFF_RX && i_uart_rx_present[dec_chan]) begin
                            o_uart_rd_ready <= N_CH'(1) << dec_chan;
                            state           <= RX_WAIT;
                        end else begin
                            o_mmio_data     <= read_word;
                            o_mmio_rd_valid <= 1'b1;
                        end
                    end
                end
                TX_WAIT: begin
                    if ((i_uart_wr_ready & o_uart_wr_valid) != '0) begin
                        o_uart_wr_valid <= '0;
                        o_uart_data     <= '0;
                        o_mmio_wr_ready <= 1'b1;
                        state           <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        o_uart_wr_valid <= '0;
                        o_uart_data     <= '0;
                        o_mmio_wr_ready <= 1'b1;
                        o_bad_addr      <= 1'b1;
                        state           <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RX_WAIT: begin
                    if ((i_uart_rd_valid & o_uart_rd_ready) != '0) begin
                        o_uart_rd_ready <= '0;
                        o_mmio_data     <= DATA_WIDTH'(rx_byte[lat_chan]);
                        o_mmio_rd_valid <= 1'b1;
                        state           <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        o_uart_rd_ready <= '0;
                        o_mmio_rd_valid <= 1'b1;
                        o_bad_addr      <= 1'b1;
                        state           <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    o_mmio_wr_ready <= 1'b0;
                    o_mmio_rd_valid <= 1'b0;
                    o_mmio_data     <= '0;
                    o_bad_addr      <= 1'b0;
                    wait_cnt        <= '0;
                    state           <= HOLD;
                end
                HOLD: begin
                    if (!i_mmio_wr_valid && !i_mmio_rd_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= |((ie_rx & i_uart_rx_present) | (ie_tx & tx_empty));
        end
    end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed bench for mmio_uart_bridge: a table of single-response register accesses
// plus hand-written TX/RX handshake, interrupt, held-request, timeout and reset sequences.
module tb_mmio_uart_bridge;

    localparam int N_CH    = 2;
    localparam int DW      = 32;
    localparam int TIMEOUT = 255;

    logic          i_clk;
    logic          i_rst;
    logic [31:0]   i_mmio_addr;
    logic [DW-1:0] i_mmio_data;
    logic          i_mmio_wr_valid;
    logic          o_mmio_wr_ready;
    logic          i_mmio_rd_ready;
    logic          o_mmio_rd_valid;
    logic [DW-1:0] o_mmio_data;
    logic [15:0]   o_uart_data;
    logic [1:0]    o_uart_wr_valid;
    logic [1:0]    i_uart_wr_ready;
    logic [9:0]    i_uart_tx_free;
    logic [1:0]    i_uart_rx_present;
    logic [15:0]   i_uart_data;
    logic [1:0]    i_uart_rd_valid;
    logic [1:0]    o_uart_rd_ready;
    logic          o_irq;
    logic          o_bad_addr;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  rx_present;
        logic [9:0]  tx_free;
        logic [31:0] exp_data;
        logic        exp_bad;
    } vec_t;

    vec_t vecs[$];

    mmio_uart_bridge #(
        .N_CH          (N_CH),
        .DATA_WIDTH    (DW),
        .TX_FIFO_DEPTH (4),
        .BASE_ADDR     (16'hFF00),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_mmio_addr       (i_mmio_addr),
        .i_mmio_data       (i_mmio_data),
        .i_mmio_wr_valid   (i_mmio_wr_valid),
        .o_mmio_wr_ready   (o_mmio_wr_ready),
        .i_mmio_rd_ready   (i_mmio_rd_ready),
        .o_mmio_rd_valid   (o_mmio_rd_valid),
        .o_mmio_data       (o_mmio_data),
        .o_uart_data       (o_uart_data),
        .o_uart_wr_valid   (o_uart_wr_valid),
        .i_uart_wr_ready   (i_uart_wr_ready),
        .i_uart_tx_free    (i_uart_tx_free),
        .i_uart_rx_present (i_uart_rx_present),
        .i_uart_data       (i_uart_data),
        .i_uart_rd_valid   (i_uart_rd_valid),
        .o_uart_rd_ready   (o_uart_rd_ready),
        .o_irq             (o_irq),
        .o_bad_addr        (o_bad_addr)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, required finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic is_wr, input logic [31:0] addr, input logic [31:0] wdata);
        i_mmio_addr     = addr;
        i_mmio_data     = wdata;
        i_mmio_wr_valid = is_wr;
        i_mmio_rd_ready = !is_wr;
    endtask

    task automatic applyStimulus(input vec_t v);
        i_uart_rx_present = v.rx_present;
        i_uart_tx_free    = v.tx_free;
        drive(v.is_wr, v.addr, v.wdata);
        tick();
    endtask

    task automatic finishTxn(input string name);
        i_mmio_wr_valid = 1'b0;
        i_mmio_rd_ready = 1'b0;
        tick();
        checkOutput({name, ".pulse_low"}, {30'd0, o_mmio_wr_ready, o_mmio_rd_valid}, 32'd0);
        checkOutput({name, ".data_low"}, o_mmio_data, 32'd0);
        checkOutput({name, ".bad_low"}, {31'd0, o_bad_addr}, 32'd0);
        tick();
    endtask

    initial begin
        int          vcnt;
        int          rcnt;
        int          bcnt;
        int          resp_cycle;
        logic        bad_seen;
        logic [1:0]  valid_at_resp;

        n_compared        = 0;
        n_mismatched      = 0;
        i_rst             = 1'b0;
        i_uart_wr_ready   = '0;
        i_uart_rd_valid   = '0;
        i_uart_data       = '0;
        i_uart_rx_present = 2'b01;
        i_uart_tx_free    = 10'h010;
        drive(1'b0, 32'h0000_FF02, 32'd0);

        // Reset holds every output low even with a request pending
        tick();
        tick();
        checkOutput("reset.mmio", {29'd0, o_mmio_wr_ready, o_mmio_rd_valid, o_bad_addr}, 32'd0);
        checkOutput("reset.data", o_mmio_data, 32'd0);
        checkOutput("reset.uart", {12'd0, o_uart_wr_valid, o_uart_rd_ready, o_uart_data}, 32'd0);
        checkOutput("reset.irq", {31'd0, o_irq}, 32'd0);
        i_rst = 1'b1;
        tick();
        checkOutput("reset.held_rd_valid", {31'd0, o_mmio_rd_valid}, 32'd1);
        checkOutput("reset.held_status", o_mmio_data, 32'h5);
        finishTxn("reset.held");

        vecs.push_back('{1'b1, 32'h0000_FF03, 32'h0000_0002, 2'b00, 10'h000, 32'h0,   1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF03, 32'h0,         2'b00, 10'h000, 32'h2,   1'b0});
        vecs.push_back('{1'b1, 32'h0000_FF07, 32'hFFFF_FFFD, 2'b00, 10'h000, 32'h0,   1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF07, 32'h0,         2'b00, 10'h000, 32'h1,   1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF02, 32'h0,         2'b01, 10'h060, 32'h3,   1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF06, 32'h0,         2'b01, 10'h200, 32'h4,   1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF06, 32'h0,         2'b10, 10'h0E0, 32'h1,   1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF04, 32'h0,         2'b00, 10'h200, 32'h10,  1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF00, 32'h0,         2'b00, 10'h005, 32'h5,   1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF05, 32'h0,         2'b01, 10'h000, 32'h100, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF01, 32'h0,         2'b10, 10'h000, 32'h100, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF08, 32'h0,         2'b00, 10'h000, 32'h0,   1'b1});
        vecs.push_back('{1'b0, 32'h0000_FEFF, 32'h0,         2'b00, 10'h000, 32'h0,   1'b1});
        vecs.push_back('{1'b1, 32'h0000_FF01, 32'h55,        2'b00, 10'h000, 32'h0,   1'b1});
        vecs.push_back('{1'b1, 32'h0000_FF02, 32'h55,        2'b00, 10'h000, 32'h0,   1'b1});
        vecs.push_back('{1'b0, 32'h0001_FF00, 32'h0,         2'b00, 10'h005, 32'h0,   1'b1});
        vecs.push_back('{1'b0, 32'h0001_FF02, 32'h0,         2'b00, 10'h060, 32'h2,   1'b0});
        vecs.push_back('{1'b1, 32'h0001_FF03, 32'h0,         2'b00, 10'h000, 32'h0,   1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF03, 32'h0,         2'b00, 10'h000, 32'h0,   1'b0});
        vecs.push_back('{1'b1, 32'h0000_FF07, 32'h0,         2'b00, 10'h000, 32'h0,   1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF07, 32'h0,         2'b00, 10'h000, 32'h0,   1'b0});
        vecs.push_back('{1'b0, 32'h0000_FF10, 32'h0,         2'b00, 10'h000, 32'h0,   1'b1});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d.wr_ready", i), {31'd0, o_mmio_wr_ready}, {31'd0, vecs[i].is_wr});
            checkOutput($sformatf("v%0d.rd_valid", i), {31'd0, o_mmio_rd_valid}, {31'd0, !vecs[i].is_wr});
            checkOutput($sformatf("v%0d.data", i), o_mmio_data, vecs[i].exp_data);
            checkOutput($sformatf("v%0d.bad", i), {31'd0, o_bad_addr}, {31'd0, vecs[i].exp_bad});
            checkOutput($sformatf("v%0d.uart_idle", i), {28'd0, o_uart_wr_valid, o_uart_rd_ready}, 32'd0);
            finishTxn($sformatf("v%0d", i));
        end

        // TX write to channel 1; the UART accepts after three valid cycles
        i_uart_tx_free = 10'h000;
        drive(1'b1, 32'h0000_FF04, 32'hABCD_EF41);
        vcnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_uart_wr_valid == 2'b10) vcnt++;
            checkOutput($sformatf("tx.lane_c%0d", i), {16'd0, o_uart_data}, 32'h4100);
        end
        checkOutput("tx.early_ready", {31'd0, o_mmio_wr_ready}, 32'd0);
        i_uart_wr_ready = 2'b10;
        tick();
        i_uart_wr_ready = 2'b00;
        checkOutput("tx.valid_cycles", vcnt, 32'd3);
        checkOutput("tx.wr_ready", {31'd0, o_mmio_wr_ready}, 32'd1);
        checkOutput("tx.valid_dropped", {30'd0, o_uart_wr_valid}, 32'd0);
        finishTxn("tx");

        // RX read on channel 0 with a byte delivered two cycles later
        i_uart_rx_present = 2'b01;
        drive(1'b0, 32'h0000_FF01, 32'd0);
        tick();
        checkOutput("rx.rd_ready_c0", {30'd0, o_uart_rd_ready}, 32'd1);
        tick();
        checkOutput("rx.rd_ready_c1", {30'd0, o_uart_rd_ready}, 32'd1);
        checkOutput("rx.early_valid", {31'd0, o_mmio_rd_valid}, 32'd0);
        i_uart_data     = 16'hC35A;
        i_uart_rd_valid = 2'b01;
        tick();
        i_uart_rd_valid = 2'b00;
        checkOutput("rx.rd_valid", {31'd0, o_mmio_rd_valid}, 32'd1);
        checkOutput("rx.data", o_mmio_data, 32'h5A);
        checkOutput("rx.rd_ready_dropped", {30'd0, o_uart_rd_ready}, 32'd0);
        finishTxn("rx");

        // Interrupt from ie_rx, then from ie_tx with an empty TX FIFO, then disabled
        i_uart_rx_present = 2'b01;
        i_uart_tx_free    = 10'h063;
        tick();
        checkOutput("irq.off", {31'd0, o_irq}, 32'd0);
        drive(1'b1, 32'h0000_FF03, 32'h3);
        tick();
        i_mmio_wr_valid = 1'b0;
        tick();
        checkOutput("irq.rx_on", {31'd0, o_irq}, 32'd1);
        tick();
        i_uart_rx_present = 2'b00;
        i_uart_tx_free    = 10'h070;
        tick();
        checkOutput("irq.tx_empty", {31'd0, o_irq}, 32'd1);
        i_uart_tx_free = 10'h063;
        tick();
        checkOutput("irq.none_pending", {31'd0, o_irq}, 32'd0);
        i_uart_rx_present = 2'b01;
        tick();
        checkOutput("irq.rx_again", {31'd0, o_irq}, 32'd1);
        drive(1'b1, 32'h0000_FF03, 32'h0);
        tick();
        i_mmio_wr_valid = 1'b0;
        tick();
        checkOutput("irq.disabled", {31'd0, o_irq}, 32'd0);
        tick();

        // Unmapped read held for several cycles answers exactly once
        drive(1'b0, 32'h0000_FF10, 32'd0);
        rcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_mmio_rd_valid) rcnt++;
            if (o_bad_addr) bcnt++;
        end
        checkOutput("held.rd_valid_count", rcnt, 32'd1);
        checkOutput("held.bad_count", bcnt, 32'd1);
        finishTxn("held");

        // TX write that the UART never accepts
        i_uart_wr_ready = 2'b00;
        drive(1'b1, 32'h0000_FF00, 32'h77);
        vcnt          = 0;
        resp_cycle    = 0;
        bad_seen      = 1'b0;
        valid_at_resp = 2'b11;
        for (int i = 1; i <= TIMEOUT + 10 && resp_cycle == 0; i++) begin
            tick();
            if (o_uart_wr_valid[0]) vcnt++;
            if (o_mmio_wr_ready) begin
                resp_cycle    = i;
                bad_seen      = o_bad_addr;
                valid_at_resp = o_uart_wr_valid;
            end
        end
        checkOutput("timeout.resp_cycle", resp_cycle, TIMEOUT + 1);
        checkOutput("timeout.bad", {31'd0, bad_seen}, 32'd1);
        checkOutput("timeout.valid_cycles", vcnt, TIMEOUT);
        checkOutput("timeout.valid_dropped", {30'd0, valid_at_resp}, 32'd0);
        finishTxn("timeout");

        // Reset in the middle of a TX handshake
        applyStimulus('{1'b1, 32'h0000_FF07, 32'h3, 2'b00, 10'h000, 32'h0, 1'b0});
        finishTxn("ctrl_c1");
        drive(1'b1, 32'h0000_FF04, 32'h99);
        tick();
        checkOutput("midrst.valid_before", {30'd0, o_uart_wr_valid}, 32'h2);
        #2;
        i_rst = 1'b0;
        #1;
        checkOutput("midrst.valid_async", {30'd0, o_uart_wr_valid}, 32'd0);
        checkOutput("midrst.data_async", {16'd0, o_uart_data}, 32'd0);
        i_mmio_wr_valid = 1'b0;
        tick();
        i_rst = 1'b1;
        applyStimulus('{1'b0, 32'h0000_FF07, 32'h0, 2'b00, 10'h000, 32'h0, 1'b0});
        checkOutput("midrst.idle_rd_valid", {31'd0, o_mmio_rd_valid}, 32'd1);
        checkOutput("midrst.ctrl_cleared", o_mmio_data, 32'd0);
        finishTxn("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
